ste_snd_dma_ctrl: RTL and testbench

//  STE DMA-sound sequencer feeding the gstshifter audio FIFO. Holds frame start/end/counter

---
 rtl/ste_snd_pkg.sv | 34 +++
 rtl/ste_snd_dma_ctrl_if.sv | 34 +++
 rtl/snd_frame_cnt.sv | 53 +++++
 rtl/ste_snd_dma_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ste_snd_dma_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ste_snd_pkg.sv
// ============================================================================
// ste_snd_pkg - register map, control bits and sequencer states for STE DMA sound
// Rev 1.0
// ============================================================================
`default_nettype none

package ste_snd_pkg;

    localparam int SND_ADDR_W = 23;

    localparam logic [4:0] SND_CTRL     = 5'd0;
    localparam logic [4:0] SND_START_HI = 5'd1;
    localparam logic [4:0] SND_START_MI = 5'd2;
    localparam logic [4:0] SND_START_LO = 5'd3;
    localparam logic [4:0] SND_CNT_HI   = 5'd4;
    localparam logic [4:0] SND_CNT_MI   = 5'd5;
    localparam logic [4:0] SND_CNT_LO   = 5'd6;
    localparam logic [4:0] SND_END_HI   = 5'd7;
    localparam logic [4:0] SND_END_MI   = 5'd8;
    localparam logic [4:0] SND_END_LO   = 5'd9;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_LOOP_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2,
        STEP = 2'd3
    } snd_state_e;

endpackage

`default_nettype wire

// File: rtl/ste_snd_dma_ctrl_if.sv
// ============================================================================
// ste_snd_dma_ctrl_if - CPU register bus plus FIFO/memory-slot handshake
// Rev 1.0
// ============================================================================
`default_nettype none

interface ste_snd_dma_ctrl_if #(
    parameter int ADDR_W = 23
) ();
    logic              cs;
    logic              rw;
    logic [4:0]        a;
    logic [7:0]        din;
    logic [7:0]        dout;
    logic              sreq;
    logic              slot;
    logic              snd_req;
    logic [ADDR_W-1:0] addr;
    logic              sload_n;
    logic              sint;
    logic              sactive;

    modport master (
        output cs, rw, a, din, sreq, slot,
        input  dout, snd_req, addr, sload_n, sint, sactive
    );

    modport slave (
        input  cs, rw, a, din, sreq, slot,
        output dout, snd_req, addr, sload_n, sint, sactive
    );
endinterface

`default_nettype wire

// File: rtl/snd_frame_cnt.sv
// ============================================================================
// snd_frame_cnt - frame word counter with latched end address and end compare
// Rev 1.0
// ============================================================================
`default_nettype none

module snd_frame_cnt #(
    parameter int ADDR_W = 23
) (
    input  logic              clk32,
    input  logic              resb,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] start_i,
    input  logic [ADDR_W-1:0] end_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              last_o,
    output logic              empty_o
);
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W-1:0] w_cnt_inc;

    assign w_cnt_inc = cnt_q + ADDR_W'(1);

    always_comb begin
        cnt_d = cnt_q;
        end_d = end_q;
        if (load_i) begin
            cnt_d = start_i;
            end_d = end_i;
        end else if (inc_i) begin
            cnt_d = w_cnt_inc;
        end
    end

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            cnt_q <= '0;
            end_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            end_q <= end_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign last_o  = (w_cnt_inc == end_q);
    assign empty_o = (cnt_q == end_q);

endmodule

`default_nettype wire

// File: rtl/ste_snd_dma_ctrl.sv
// ============================================================================
// ste_snd_dma_ctrl - STE DMA-sound sequencer: register file, slot FSM, FIFO load strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module ste_snd_dma_ctrl
    import ste_snd_pkg::*;
#(
    parameter int LOAD_CYCLES = 4,
    parameter int ADDR_W      = SND_ADDR_W
) (
    input  logic              clk32,
    input  logic              resb,
    ste_snd_dma_ctrl_if.slave bus
);
    localparam int              TMR_W    = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOAD_CYCLES - 1);

    logic              cs_q;
    logic              en_q;
    logic              loop_q;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] end_q;

    snd_state_e        state_q;
    logic [TMR_W-1:0]  tmr_q;
    logic              snd_req_q;
    logic              sload_n_q;
    logic              sint_q;
    logic [ADDR_W-1:0] addr_q;

    logic              w_wr;
    logic              w_en_rise;
    logic [ADDR_W-1:0] w_cnt;
    logic              w_last;
    logic              w_cnt_empty;
    logic              w_empty_stop;
    logic              w_frame_end;
    logic              w_reload;
    logic              w_clr_en;
    logic [7:0]        w_dout;

    // One write pulse per bus access, taken on the first cycle cs is seen high.
    assign w_wr      = bus.cs & ~cs_q & ~bus.rw;
    assign w_en_rise = w_wr && (bus.a == SND_CTRL) && bus.din[CTRL_EN_BIT] && !en_q;

    assign w_empty_stop = (state_q == IDLE) && en_q && w_cnt_empty;
    assign w_frame_end  = (state_q == STEP) && en_q && w_last;
    assign w_reload     = w_frame_end && loop_q && (start_q != end_q);
    assign w_clr_en     = w_empty_stop || (w_frame_end && !w_reload);

    snd_frame_cnt #(.ADDR_W(ADDR_W)) u_frame_cnt (
        .clk32   (clk32),
        .resb    (resb),
        .load_i  (w_en_rise || w_reload),
        .inc_i   (state_q == STEP),
        .start_i (start_q),
        .end_i   (end_q),
        .cnt_o   (w_cnt),
        .last_o  (w_last),
        .empty_o (w_cnt_empty)
    );

    // Byte-register mapping assumes a 24-bit byte address (word bits [22:0]).
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            cs_q    <= 1'b0;
            en_q    <= 1'b0;
            loop_q  <= 1'b0;
            start_q <= '0;
            end_q   <= '0;
        end else begin
            cs_q <= bus.cs;
            if (w_clr_en) begin
                en_q <= 1'b0;
            end
            if (w_wr) begin
                case (bus.a)
                    SND_CTRL: begin
                        en_q   <= bus.din[CTRL_EN_BIT];
                        loop_q <= bus.din[CTRL_LOOP_BIT];
                    end
                    SND_START_HI: start_q[22:15] <= bus.din;
                    SND_START_MI: start_q[14:7]  <= bus.din;
                    SND_START_LO: start_q[6:0]   <= bus.din[7:1];
                    SND_END_HI:   end_q[22:15]   <= bus.din;
                    SND_END_MI:   end_q[14:7]    <= bus.din;
                    SND_END_LO:   end_q[6:0]     <= bus.din[7:1];
                    default: ;
                endcase
            end
        end
    end

    // snd_req is registered, so it follows sreq one cycle late while in REQ.
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            snd_req_q <= 1'b0;
            sload_n_q <= 1'b1;
            sint_q    <= 1'b0;
            addr_q    <= '0;
        end else begin
            snd_req_q <= 1'b0;
            sint_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en_q) begin
                        if (w_cnt_empty) begin
                            sint_q <= 1'b1;
                        end else begin
                            state_q   <= REQ;
                            snd_req_q <= bus.sreq;
                        end
                    end
                end
                REQ: begin
                    if (!en_q) begin
                        state_q <= IDLE;
                    end else if (bus.slot && bus.sreq) begin
                        state_q   <= LOAD;
                        sload_n_q <= 1'b0;
                        addr_q    <= w_cnt;
                        tmr_q     <= TMR_LAST;
                    end else begin
                        snd_req_q <= bus.sreq;
                    end
                end
                LOAD: begin
                    if (tmr_q == '0) begin
                        sload_n_q <= 1'b1;
                        state_q   <= STEP;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                STEP: begin
                    if (w_frame_end) begin
                        sint_q <= 1'b1;
                        if (w_reload) begin
                            state_q   <= REQ;
                            snd_req_q <= bus.sreq;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (en_q) begin
                        state_q   <= REQ;
                        snd_req_q <= bus.sreq;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_dout = 8'h00;
        case (bus.a)
            SND_CTRL:     w_dout = {6'b0, loop_q, en_q};
            SND_START_HI: w_dout = start_q[22:15];
            SND_START_MI: w_dout = start_q[14:7];
            SND_START_LO: w_dout = {start_q[6:0], 1'b0};
            SND_CNT_HI:   w_dout = w_cnt[22:15];
            SND_CNT_MI:   w_dout = w_cnt[14:7];
            SND_CNT_LO:   w_dout = {w_cnt[6:0], 1'b0};
            SND_END_HI:   w_dout = end_q[22:15];
            SND_END_MI:   w_dout = end_q[14:7];
            SND_END_LO:   w_dout = {end_q[6:0], 1'b0};
            default:      w_dout = 8'h00;
        endcase
    end

    assign bus.dout    = w_dout;
    assign bus.snd_req = snd_req_q;
    assign bus.addr    = addr_q;
    assign bus.sload_n = sload_n_q;
    assign bus.sint    = sint_q;
    assign bus.sactive = en_q;

endmodule

`default_nettype wire

// File: tb/tb_ste_snd_dma_ctrl.sv
// ============================================================================
// tb_ste_snd_dma_ctrl - directed self-checking bench for the DMA-sound sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ste_snd_dma_ctrl;
    import ste_snd_pkg::*;

    logic clk32 = 1'b0;
    logic resb  = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    ste_snd_dma_ctrl_if #(.ADDR_W(23)) u_if ();

    ste_snd_dma_ctrl #(.LOAD_CYCLES(4), .ADDR_W(23)) u_dut (
        .clk32 (clk32),
        .resb  (resb),
        .bus   (u_if.slave)
    );

    always #16 clk32 = ~clk32;

    // Memory slot granted to sound once every 16 clocks.
    logic slot_en = 1'b0;
    int   slot_div = 0;
    always @(negedge clk32) begin
        if (slot_en) begin
            slot_div   = (slot_div == 15) ? 0 : slot_div + 1;
            u_if.slot  = (slot_div == 0);
        end else begin
            slot_div   = 0;
            u_if.slot  = 1'b0;
        end
    end

    // Observers: fetch addresses, strobe lengths, frame-end pulses.
    logic [22:0] addrs[$];
    int   n_sint = 0;
    int   bad_len = 0;
    int   load_len = 0;
    int   loads_at_sint = -1;
    logic req_seen = 1'b0;
    logic prev_sload_n = 1'b1;
    always @(negedge clk32) begin
        if (u_if.sload_n === 1'b0) begin
            if (prev_sload_n) begin
                addrs.push_back(u_if.addr);
                load_len = 1;
            end else begin
                load_len++;
            end
        end else if (!prev_sload_n) begin
            if (load_len != 4) bad_len++;
        end
        if (u_if.sint === 1'b1) begin
            n_sint++;
            loads_at_sint = addrs.size();
        end
        if (u_if.snd_req === 1'b1) req_seen = 1'b1;
        prev_sload_n = (u_if.sload_n !== 1'b0);
    end

    logic [7:0] rdata;

    task automatic tick();
        @(negedge clk32);
        #1;
    endtask

    task automatic clr_mon();
        @(posedge clk32);
        addrs.delete();
        n_sint = 0;
        bad_len = 0;
        loads_at_sint = -1;
        req_seen = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk32);
        u_if.a   = a;
        u_if.din = d;
        u_if.rw  = 1'b0;
        u_if.cs  = 1'b1;
        @(negedge clk32);
        u_if.cs  = 1'b0;
        u_if.rw  = 1'b1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        u_if.a  = a;
        u_if.rw = 1'b1;
        #1;
        d = u_if.dout;
    endtask

    task automatic set_frame(input logic [23:0] s, input logic [23:0] e);
        wr(SND_START_HI, s[23:16]);
        wr(SND_START_MI, s[15:8]);
        wr(SND_START_LO, s[7:0]);
        wr(SND_END_HI, e[23:16]);
        wr(SND_END_MI, e[15:8]);
        wr(SND_END_LO, e[7:0]);
    endtask

    task automatic stop_dma();
        wr(SND_CTRL, 8'h00);
        repeat (10) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (u_if.sload_n !== 1'b1 || u_if.snd_req !== 1'b0 || u_if.sint !== 1'b0 ||
            u_if.sactive !== 1'b0 || u_if.addr !== 23'h0) begin
            failures++;
            $display("FAIL reset_outputs sload_n=%b snd_req=%b sint=%b sactive=%b addr=%h required 1 0 0 0 0",
                     u_if.sload_n, u_if.snd_req, u_if.sint, u_if.sactive, u_if.addr);
        end
        @(negedge clk32);
        resb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd(5'(i), rdata);
            checks++;
            if (rdata !== 8'h00) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h required 00", i, rdata);
            end
        end
    endtask

    task automatic test_regs();
        logic [7:0] exp_v [10];
        exp_v = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'hAB, 8'hCD, 8'hEE};
        set_frame(24'h123457, 24'hABCDEF);
        for (int i = 0; i < 10; i++) begin
            rd(5'(i), rdata);
            checks++;
            if (rdata !== exp_v[i]) begin
                failures++;
                $display("FAIL regs_rd%0d got=%h required %h", i, rdata, exp_v[i]);
            end
        end
        rd(5'd12, rdata);
        checks++;
        if (rdata !== 8'h00) begin
            failures++;
            $display("FAIL regs_unmapped got=%h required 00", rdata);
        end
    endtask

    task automatic test_basic();
        set_frame(24'h010000, 24'h010008);
        clr_mon();
        wr(SND_CTRL, 8'h01);
        tick();
        checks++;
        if (u_if.sactive !== 1'b1) begin
            failures++;
            $display("FAIL basic_active got=%b required 1", u_if.sactive);
        end
        for (int k = 0; k < 2000 && u_if.sactive === 1'b1; k++) tick();
        repeat (5) tick();
        checks++;
        if (u_if.sactive !== 1'b0) begin
            failures++;
            $display("FAIL basic_done sactive=%b required 0", u_if.sactive);
        end
        checks++;
        if (addrs.size() != 4) begin
            failures++;
            $display("FAIL basic_nload got=%0d required 4", addrs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addrs[i] !== 23'h8000 + 23'(i)) begin
                    failures++;
                    $display("FAIL basic_addr%0d got=%h required %h", i, addrs[i], 23'h8000 + 23'(i));
                end
            end
        end
        checks++;
        if (bad_len != 0 || n_sint != 1 || loads_at_sint != 4) begin
            failures++;
            $display("FAIL basic_strobe bad_len=%0d sint=%0d loads_at_sint=%0d required 0 1 4",
                     bad_len, n_sint, loads_at_sint);
        end
        rd(SND_CNT_LO, rdata);
        checks++;
        if (rdata !== 8'h08) begin
            failures++;
            $display("FAIL basic_cnt_lo got=%h required 08", rdata);
        end
    endtask

    task automatic test_loop();
        logic [22:0] exp_a [8];
        exp_a = '{23'h8000, 23'h8001, 23'h8002, 23'h8003, 23'h8000, 23'h8001, 23'h8000, 23'h8001};
        set_frame(24'h010000, 24'h010008);
        clr_mon();
        wr(SND_CTRL, 8'h03);
        for (int k = 0; k < 100 && addrs.size() == 0; k++) tick();
        wr(SND_END_LO, 8'h04);
        for (int k = 0; k < 1500 && n_sint < 3; k++) tick();
        checks++;
        if (n_sint != 3) begin
            failures++;
            $display("FAIL loop_sint got=%0d required 3", n_sint);
        end
        rd(SND_CNT_HI, rdata);
        checks++;
        if (rdata !== 8'h01) begin
            failures++;
            $display("FAIL loop_cnt_hi got=%h required 01", rdata);
        end
        rd(SND_CNT_LO, rdata);
        checks++;
        if (rdata !== 8'h00) begin
            failures++;
            $display("FAIL loop_cnt_lo got=%h required 00", rdata);
        end
        checks++;
        if (addrs.size() < 8) begin
            failures++;
            $display("FAIL loop_nload got=%0d required 8", addrs.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (addrs[i] !== exp_a[i]) begin
                    failures++;
                    $display("FAIL loop_addr%0d got=%h required %h", i, addrs[i], exp_a[i]);
                end
            end
        end
        checks++;
        if (u_if.sactive !== 1'b1) begin
            failures++;
            $display("FAIL loop_active got=%b required 1", u_if.sactive);
        end
        stop_dma();
    endtask

    task automatic test_sreq();
        set_frame(24'h010000, 24'h010010);
        u_if.sreq = 1'b0;
        clr_mon();
        wr(SND_CTRL, 8'h01);
        repeat (100) tick();
        checks++;
        if (addrs.size() != 0 || req_seen !== 1'b0) begin
            failures++;
            $display("FAIL sreq_block loads=%0d snd_req_seen=%b required 0 0", addrs.size(), req_seen);
        end
        @(negedge clk32);
        u_if.sreq = 1'b1;
        for (int k = 0; k < 20 && addrs.size() == 0; k++) tick();
        checks++;
        if (addrs.size() != 1 || req_seen !== 1'b1) begin
            failures++;
            $display("FAIL sreq_resume loads=%0d snd_req_seen=%b required 1 1", addrs.size(), req_seen);
        end else begin
            checks++;
            if (addrs[0] !== 23'h8000) begin
                failures++;
                $display("FAIL sreq_addr got=%h required 8000", addrs[0]);
            end
        end
        stop_dma();
    endtask

    task automatic test_empty();
        set_frame(24'h020000, 24'h020000);
        clr_mon();
        wr(SND_CTRL, 8'h03);
        repeat (50) tick();
        checks++;
        if (addrs.size() != 0 || n_sint != 1) begin
            failures++;
            $display("FAIL empty_frame loads=%0d sint=%0d required 0 1", addrs.size(), n_sint);
        end
        rd(SND_CTRL, rdata);
        checks++;
        if (rdata !== 8'h02 || u_if.sactive !== 1'b0) begin
            failures++;
            $display("FAIL empty_ctrl got=%h sactive=%b required 02 0", rdata, u_if.sactive);
        end
    endtask

    task automatic test_en_clear();
        set_frame(24'h010000, 24'h010010);
        clr_mon();
        wr(SND_CTRL, 8'h01);
        for (int k = 0; k < 40 && u_if.sload_n !== 1'b0; k++) tick();
        wr(SND_CTRL, 8'h00);
        repeat (40) tick();
        checks++;
        if (addrs.size() != 1 || bad_len != 0 || u_if.sload_n !== 1'b1) begin
            failures++;
            $display("FAIL enclr_strobe loads=%0d bad_len=%0d sload_n=%b required 1 0 1",
                     addrs.size(), bad_len, u_if.sload_n);
        end
        checks++;
        if (n_sint != 0 || u_if.sactive !== 1'b0 || u_if.snd_req !== 1'b0) begin
            failures++;
            $display("FAIL enclr_state sint=%0d sactive=%b snd_req=%b required 0 0 0",
                     n_sint, u_if.sactive, u_if.snd_req);
        end
        rd(SND_CNT_LO, rdata);
        checks++;
        if (rdata !== 8'h02) begin
            failures++;
            $display("FAIL enclr_cnt_lo got=%h required 02", rdata);
        end
    endtask

    task automatic test_reset_mid();
        set_frame(24'h010000, 24'h010010);
        clr_mon();
        wr(SND_CTRL, 8'h01);
        for (int k = 0; k < 40 && u_if.sload_n !== 1'b0; k++) tick();
        checks++;
        if (u_if.sload_n !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_load got sload_n=%b required 0", u_if.sload_n);
        end
        #3;
        resb = 1'b0;
        #1;
        checks++;
        if (u_if.sload_n !== 1'b1 || u_if.snd_req !== 1'b0 || u_if.sactive !== 1'b0 || u_if.addr !== 23'h0) begin
            failures++;
            $display("FAIL rstmid_outputs sload_n=%b snd_req=%b sactive=%b addr=%h required 1 0 0 0",
                     u_if.sload_n, u_if.snd_req, u_if.sactive, u_if.addr);
        end
        for (int i = 0; i < 10; i++) begin
            rd(5'(i), rdata);
            checks++;
            if (rdata !== 8'h00) begin
                failures++;
                $display("FAIL rstmid_reg%0d got=%h required 00", i, rdata);
            end
        end
        @(negedge clk32);
        resb = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        u_if.cs   = 1'b0;
        u_if.rw   = 1'b1;
        u_if.a    = 5'd0;
        u_if.din  = 8'h00;
        u_if.sreq = 1'b1;
        test_reset();
        test_regs();
        slot_en = 1'b1;
        test_basic();
        test_loop();
        test_sreq();
        test_empty();
        test_en_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
